// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream arbiter/mux slice.
package axis_pkg;

    localparam int unsigned RR_MAX = 16;
    localparam int unsigned RR_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_t;

    // First set bit of req at or after ptr, wrapping at n; returns ptr when req is empty.
    function automatic logic [RR_W-1:0] rr_select(input logic [RR_MAX-1:0] req,
                                                  input logic [RR_W-1:0]   ptr,
                                                  input int unsigned       n);
        logic [RR_W-1:0] sel;
        logic [RR_W-1:0] idx;
        logic            found;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            idx = RR_W'((32'(ptr) + k) % n);
            if ((k < n) && !found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle with transmitter/receiver views.
interface AXIS_IF #(
    parameter int TDATA_WIDTH = 8,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1
);
    localparam int KEEP_WIDTH = TDATA_WIDTH / 8;

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0]  tkeep;
    logic [KEEP_WIDTH-1:0]  tstrb;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;
    logic                   twakeup;

    modport Transmitter (
        output tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest, twakeup,
        input  tready
    );

    modport Receiver (
        input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest, twakeup,
        output tready
    );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry registered AXI-Stream slice: registered tvalid out, registered tready in.
module axis_skid_buffer #(
    parameter int TDATA_WIDTH = 8,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1
) (
    input logic         clk,
    input logic         rst,
    AXIS_IF.Receiver    s_axis,
    AXIS_IF.Transmitter m_axis
);

    localparam int KW = TDATA_WIDTH / 8;
    localparam int W  = TDATA_WIDTH + 2 * KW + 1 + TUSER_WIDTH + TID_WIDTH + TDEST_WIDTH + 1;

    logic [W-1:0] in_bus;
    logic [W-1:0] out_q;
    logic [W-1:0] skid_q;
    logic         out_valid_q;
    logic         skid_valid_q;
    logic         push;

    assign in_bus = {s_axis.tdata, s_axis.tkeep, s_axis.tstrb, s_axis.tlast,
                     s_axis.tuser, s_axis.tid, s_axis.tdest, s_axis.twakeup};

    // Upstream ready depends only on skid occupancy, never on m_axis.tready.
    assign s_axis.tready = ~skid_valid_q;
    assign push          = s_axis.tvalid & ~skid_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || m_axis.tready) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (push) begin
                out_q       <= in_bus;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (push) begin
            skid_q       <= in_bus;
            skid_valid_q <= 1'b1;
        end
    end

    assign m_axis.tvalid = out_valid_q;
    assign {m_axis.tdata, m_axis.tkeep, m_axis.tstrb, m_axis.tlast,
            m_axis.tuser, m_axis.tid, m_axis.tdest, m_axis.twakeup} = out_q;

endmodule

// File: rtl/axis_arb_mux.sv
// Packet-granular round-robin arbiter/mux merging NUM_INPUTS AXI-Stream sources onto one output.
module axis_arb_mux
    import axis_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int TDATA_WIDTH = 8,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = $clog2(NUM_INPUTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    AXIS_IF.Receiver                      s_axis [NUM_INPUTS],
    AXIS_IF.Transmitter                   m_axis,
    output logic                          busy,
    output logic [$clog2(NUM_INPUTS)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_INPUTS);
    localparam int KW    = TDATA_WIDTH / 8;

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [NUM_INPUTS-1:0]  req;
    logic [NUM_INPUTS-1:0]  tready_vec;
    logic [NUM_INPUTS-1:0]  unused_fields;
    logic                   unused_ok;
    logic                   accept;

    logic [TDATA_WIDTH-1:0] in_tdata   [NUM_INPUTS];
    logic [KW-1:0]          in_tkeep   [NUM_INPUTS];
    logic [KW-1:0]          in_tstrb   [NUM_INPUTS];
    logic                   in_tlast   [NUM_INPUTS];
    logic [TUSER_WIDTH-1:0] in_tuser   [NUM_INPUTS];
    logic                   in_twakeup [NUM_INPUTS];

    AXIS_IF #(
        .TDATA_WIDTH (TDATA_WIDTH),
        .TUSER_WIDTH (TUSER_WIDTH),
        .TID_WIDTH   (TID_WIDTH),
        .TDEST_WIDTH (1)
    ) mid ();

    // Interface arrays only take constant indices, so flatten them into plain arrays.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
        assign req[i]           = s_axis[i].tvalid;
        assign in_tdata[i]      = s_axis[i].tdata;
        assign in_tkeep[i]      = s_axis[i].tkeep;
        assign in_tstrb[i]      = s_axis[i].tstrb;
        assign in_tlast[i]      = s_axis[i].tlast;
        assign in_tuser[i]      = s_axis[i].tuser;
        assign in_twakeup[i]    = s_axis[i].twakeup;
        assign unused_fields[i] = ^{s_axis[i].tid, s_axis[i].tdest};
        assign s_axis[i].tready = tready_vec[i];
    end

    assign unused_ok = ^unused_fields;

    assign mid.tvalid  = (state_q == PASS) && req[grant_q];
    assign mid.tdata   = in_tdata[grant_q];
    assign mid.tkeep   = in_tkeep[grant_q];
    assign mid.tstrb   = in_tstrb[grant_q];
    assign mid.tlast   = in_tlast[grant_q];
    assign mid.tuser   = in_tuser[grant_q];
    assign mid.twakeup = in_twakeup[grant_q];
    assign mid.tid     = TID_WIDTH'(grant_q);
    assign mid.tdest   = '0;
    assign accept      = mid.tvalid & mid.tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = IDX_W'(rr_select(RR_MAX'(req), RR_W'(ptr_q), NUM_INPUTS));
                    state_d = PASS;
                end
            end
            PASS: begin
                if (accept && mid.tlast) begin
                    ptr_d   = (grant_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == PASS);
        tready_vec = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            tready_vec[i] = (state_q == PASS) && (grant_q == IDX_W'(i)) && mid.tready;
        end
    end

    assign grant_idx = grant_q;

    axis_skid_buffer #(
        .TDATA_WIDTH (TDATA_WIDTH),
        .TUSER_WIDTH (TUSER_WIDTH),
        .TID_WIDTH   (TID_WIDTH),
        .TDEST_WIDTH (1)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .s_axis (mid),
        .m_axis (m_axis)
    );

endmodule

// File: tb/tb_axis_arb_mux.sv
// Directed bench for axis_arb_mux: table of arbitration scenarios plus stall and reset sequences.
module tb_axis_arb_mux;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_ready;
    logic       busy;
    logic [1:0] grant_idx;

    always #5 clk = ~clk;

    AXIS_IF #(.TDATA_WIDTH(8), .TUSER_WIDTH(1), .TID_WIDTH(2), .TDEST_WIDTH(1)) s_if [N] ();
    AXIS_IF #(.TDATA_WIDTH(8), .TUSER_WIDTH(1), .TID_WIDTH(2), .TDEST_WIDTH(1)) m_if ();

    axis_arb_mux #(
        .NUM_INPUTS  (N),
        .TDATA_WIDTH (8),
        .TUSER_WIDTH (1),
        .TID_WIDTH   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    logic         src_valid [N];
    logic [7:0]   src_data  [N];
    logic         src_last  [N];
    logic         src_strb  [N];
    logic         src_user  [N];
    logic         src_wake  [N];
    logic [N-1:0] src_ready;

    // Input tid/tdest carry junk to show the DUT ignores them.
    for (genvar i = 0; i < N; i++) begin : g_src
        assign s_if[i].tvalid  = src_valid[i];
        assign s_if[i].tdata   = src_data[i];
        assign s_if[i].tkeep   = 1'b1;
        assign s_if[i].tstrb   = src_strb[i];
        assign s_if[i].tlast   = src_last[i];
        assign s_if[i].tuser   = src_user[i];
        assign s_if[i].twakeup = src_wake[i];
        assign s_if[i].tid     = 2'(N - 1 - i);
        assign s_if[i].tdest   = 1'b1;
        assign src_ready[i]    = s_if[i].tready;
    end
    assign m_if.tready = m_ready;

    int     errors = 0;
    int     checks = 0;
    int     cyc    = 0;
    int     npk   [N];
    int     plen  [N];
    int     beat  [N];
    bit     stall [N];
    bit     pend  [N];
    int     got   [$];
    int     cur_src, cur_beat, last_out, first_out;
    bit     chk_gap, rnd_ready, prev_hold;
    logic [15:0] prev_pl;

    typedef struct packed {
        int          pre;
        int          n0, n1, n2, n3;
        int          plen;
        logic        rnd, gap, lat;
        int          exp_n;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] payload();
        return {m_if.tdata, m_if.tkeep, m_if.tstrb, m_if.tlast, m_if.tuser,
                m_if.tid, m_if.tdest, m_if.twakeup};
    endfunction

    function automatic logic [15:0] expw(input int src, input int b, input logic last);
        logic [1:0] s;
        logic [5:0] bb;
        s  = 2'(src);
        bb = 6'(b);
        return {s, bb, 1'b1, bb[2], last, bb[0], s, 1'b0, bb[1] ^ s[0]};
    endfunction

    function automatic void drive();
        for (int i = 0; i < N; i++) begin
            logic [5:0] bb;
            logic [1:0] s;
            bb           = 6'(beat[i]);
            s            = 2'(i);
            src_valid[i] = (npk[i] > 0) && !stall[i];
            src_data[i]  = {s, bb};
            src_last[i]  = (beat[i] == plen[i] - 1);
            src_strb[i]  = bb[2];
            src_user[i]  = bb[0];
            src_wake[i]  = bb[1] ^ s[0];
        end
    endfunction

    // Re-drive sources and re-sample which of them will handshake on the next edge.
    function automatic void update();
        drive();
        for (int i = 0; i < N; i++) pend[i] = src_valid[i] && src_ready[i];
    endfunction

    task automatic cycle();
        logic [15:0] pl;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
                beat[i]++;
                if (beat[i] == plen[i]) begin
                    beat[i] = 0;
                    npk[i]--;
                end
            end
        end
        m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        drive();
        pl = payload();
        if (prev_hold) begin
            check("stall_tvalid", m_if.tvalid, 1);
            check("stall_payload", pl, prev_pl);
        end
        if (m_if.tvalid && m_ready) begin
            if (cur_src < 0) begin
                got.push_back(int'(m_if.tid));
                if (first_out < 0) first_out = cyc;
                if (chk_gap && last_out >= 0) check("pkt_gap", cyc - last_out, 2);
                cur_src  = int'(m_if.tid);
                cur_beat = 0;
            end
            check("beat", pl, expw(cur_src, cur_beat, cur_beat == plen[cur_src] - 1));
            if (m_if.tlast) begin
                last_out = cyc;
                cur_src  = -1;
            end else begin
                cur_beat++;
            end
        end
        prev_hold = m_if.tvalid && !m_ready;
        prev_pl   = pl;
        for (int i = 0; i < N; i++) pend[i] = src_valid[i] && src_ready[i];
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        prev_hold = 1'b0;
        cycle();
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_idx, 0);
        check("rst_tready", src_ready, 0);
        check("rst_payload", payload(), 0);
        cycle();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            npk[i]   = 0;
            beat[i]  = 0;
            stall[i] = 1'b0;
            plen[i]  = 1;
        end
        got.delete();
        cur_src   = -1;
        cur_beat  = 0;
        last_out  = -1;
        first_out = -1;
        prev_hold = 1'b0;
        chk_gap   = 1'b0;
        rnd_ready = 1'b0;
        update();
    endtask

    task automatic drain();
        int  n;
        bit  pending;
        n = 0;
        do begin
            cycle();
            n++;
            pending = 1'b0;
            for (int i = 0; i < N; i++) if (npk[i] > 0) pending = 1'b1;
        end while ((pending || cur_src >= 0 || m_if.tvalid || busy) && n < 2000);
        check("drain_done", n < 2000, 1);
    endtask

    task automatic wait_beat(input int src, input int k);
        int n;
        n = 0;
        while (beat[src] < k && n < 200) begin
            cycle();
            n++;
        end
        check("wait_beat", beat[src] >= k, 1);
    endtask

    function automatic vec_t mk(input int pre, input int n0, input int n1, input int n2,
                                input int n3, input int pl, input logic rnd, input logic gap,
                                input logic lat, input int en, input logic [47:0] ex);
        vec_t v;
        v.pre = pre; v.n0 = n0; v.n1 = n1; v.n2 = n2; v.n3 = n3; v.plen = pl;
        v.rnd = rnd; v.gap = gap; v.lat = lat; v.exp_n = en; v.exp = ex;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int          load_cyc;
        logic [47:0] e;
        do_reset();
        for (int i = 0; i < N; i++) plen[i] = v.plen;
        rnd_ready = v.rnd;
        if (v.pre >= 0) begin
            npk[v.pre] = 1;
            update();
            drain();
        end
        chk_gap   = v.gap;
        last_out  = -1;
        first_out = -1;
        npk[0] = v.n0; npk[1] = v.n1; npk[2] = v.n2; npk[3] = v.n3;
        load_cyc = cyc;
        update();
        drain();
        if (v.lat) check("first_latency", first_out - load_cyc, 2);
        check("pkt_count", got.size(), v.exp_n);
        for (int k = 0; k < got.size() && k < v.exp_n; k++) begin
            e = v.exp >> (4 * (v.exp_n - 1 - k));
            check("grant_order", got[k], {28'd0, e[3:0]});
        end
    endtask

    initial begin
        rst     = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            npk[i] = 0; plen[i] = 1; beat[i] = 0; stall[i] = 1'b0; pend[i] = 1'b0;
        end
        cur_src = -1; cur_beat = 0; last_out = -1; first_out = -1;
        chk_gap = 1'b0; rnd_ready = 1'b0; prev_hold = 1'b0; prev_pl = '0;
        drive();

        //          pre  n0 n1 n2 n3 plen rnd gap lat  n  order
        vecs[0] = mk(-1, 0, 0, 1, 0,  5, 0,  0,  1,  1, 48'h2);
        vecs[1] = mk(-1, 2, 2, 2, 2,  3, 0,  1,  1,  8, 48'h01230123);
        vecs[2] = mk(-1, 0, 2, 0, 2, 64, 1,  0,  0,  4, 48'h1313);
        vecs[3] = mk( 0, 2, 0, 0, 2,  4, 0,  0,  0,  5, 48'h03030);
        vecs[4] = mk( 3, 1, 0, 0, 1,  2, 0,  0,  0,  3, 48'h303);
        vecs[5] = mk(-1, 1, 1, 1, 0,  1, 0,  1,  1,  3, 48'h012);

        for (int unsigned i = 0; i < 6; i++) run_vec(vecs[i]);

        // Granted source drops tvalid mid-packet while source 1 waits.
        do_reset();
        plen[0] = 8;
        plen[1] = 2;
        npk[0]  = 1;
        update();
        cycle();
        npk[1] = 1;
        update();
        wait_beat(0, 3);
        stall[0] = 1'b1;
        update();
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("hold_busy", busy, 1);
            check("hold_grant", grant_idx, 0);
            check("hold_rdy1", src_ready[1], 0);
        end
        stall[0] = 1'b0;
        update();
        drain();
        check("hold_pkts", got.size(), 2);
        if (got.size() == 2) begin
            check("hold_order0", got[0], 0);
            check("hold_order1", got[1], 1);
        end

        // Reset in the middle of a packet after the pointer has moved to 3.
        do_reset();
        plen[2] = 2;
        npk[2]  = 1;
        update();
        drain();
        plen[0] = 8;
        npk[0]  = 1;
        update();
        wait_beat(0, 3);
        do_reset();
        plen[1] = 2;
        plen[3] = 2;
        npk[1]  = 1;
        npk[3]  = 1;
        update();
        drain();
        check("rst_pkts", got.size(), 2);
        if (got.size() == 2) begin
            check("rst_order0", got[0], 1);
            check("rst_order1", got[1], 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
